// File: rtl/scan_mux.sv
// scan_mux: registered N-to-1 multiplexer of W-bit channels.
// It has two modes. In manual mode the sel input picks the channel. In scan
// mode an internal round-robin pointer visits channels 0..N-1. It stays
// DWELL enabled cycles on each channel and then wraps back to 0.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   en         cycle enable; when low, all state holds
//   mode       0 = manual select, 1 = auto-scan
//   sel        manual channel select, used only when en=1 and mode=0
//   din        flattened channel bus; channel k is din[k*W +: W]
//   out        registered data of the selected channel
//   out_valid  out was captured from a legal channel on the last enabled edge
//   cur_sel    channel index that out was captured from
//   sel_err    the last capture used an index >= N
//   wrap       one-cycle pulse when the scan pointer wraps from N-1 to 0

module scan_mux #(
   parameter int N     = 7,
   parameter int W     = 1,
   parameter int SEL_W = 3,
   parameter int DWELL = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N*W-1:0]     din,
   output logic [W-1:0]       out,
   output logic               out_valid,
   output logic [SEL_W-1:0]   cur_sel,
   output logic               sel_err,
   output logic               wrap
);

   // The dwell counter needs at least one bit, even when DWELL is 1.
   localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   // N can be as large as 2**SEL_W, so the legality limit needs one extra bit.
   localparam logic [SEL_W:0]    N_LIM = N[SEL_W:0];
   localparam logic [SEL_W-1:0]  LAST  = SEL_W'(N - 1);
   localparam logic [DCNT_W-1:0] DLAST = DCNT_W'(DWELL - 1);

   logic [DCNT_W-1:0] dcnt;
   logic [SEL_W-1:0]  idx;
   logic [W-1:0]      pick;
   logic              idx_ok;

   // Choose the index for this edge. Manual mode uses sel. Scan mode uses the
   // pointer value from before the edge. Then pull that channel out of the
   // flat bus. An out-of-range index gives zero, and the sequential block
   // replaces that case with its error handling anyway.
   always_comb begin
      idx  = mode ? cur_sel : sel;
      pick = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == SEL_W'(k)) begin
            pick = din[k*W +: W];
         end
      end
      idx_ok = ({1'b0, idx} < N_LIM);
   end

   // All outputs and the scan state are registered in this block.
   // When en is low, the data, the pointer and the dwell counter hold.
   // The two pulse-like flags, out_valid and wrap, drop on that edge.
   // In scan mode an illegal pointer left over from manual mode is pulled
   // back to channel 0 after one error cycle. Otherwise the pointer advances
   // after DWELL enabled edges on the same channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         cur_sel   <= '0;
         sel_err   <= 1'b0;
         wrap      <= 1'b0;
         dcnt      <= '0;
      end else if (!en) begin
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else if (!mode) begin
         cur_sel <= sel;
         dcnt    <= '0;
         wrap    <= 1'b0;
         if (idx_ok) begin
            out       <= pick;
            sel_err   <= 1'b0;
            out_valid <= 1'b1;
         end else begin
            out       <= '0;
            sel_err   <= 1'b1;
            out_valid <= 1'b0;
         end
      end else if (!idx_ok) begin
         cur_sel   <= '0;
         dcnt      <= '0;
         out       <= '0;
         sel_err   <= 1'b1;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         out       <= pick;
         sel_err   <= 1'b0;
         out_valid <= 1'b1;
         if (dcnt != DLAST) begin
            dcnt <= dcnt + 1'b1;
            wrap <= 1'b0;
         end else begin
            dcnt <= '0;
            if (cur_sel == LAST) begin
               cur_sel <= '0;
               wrap    <= 1'b1;
            end else begin
               cur_sel <= cur_sel + 1'b1;
               wrap    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-to-1 multiplexer of W-bit channels. Successor to the team's gate-level 7-to-1 mux.
- Two modes:
  - Manual: the select input picks the channel.
  - Scan: an internal round-robin pointer steps through channels 0..N-1, dwelling DWELL enabled cycles on each, then wraps.
- Used as the front-end channel selector / time-division sampler feeding downstream single-channel logic.

Parameters:
- N, 7, number of input channels; 2 <= N <= 2**SEL_W.
- W, 1, bits per channel.
- SEL_W, 3, width of select and pointer.
- DWELL, 4, enabled cycles spent on each channel in scan mode; DWELL >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  cycle enable; when 0 all state holds.
- mode  input  1  0 = manual select, 1 = auto-scan.
- sel  input  SEL_W  manual channel select; sampled only when en=1 and mode=0.
- din  input  N*W  flattened channel bus; channel k occupies din[k*W +: W].
- out  output  W  registered selected channel data.
- out_valid  output  1  out holds data from a legal channel captured on the last enabled edge.
- cur_sel  output  SEL_W  channel index that out was captured from.
- sel_err  output  1  last capture used an index >= N.
- wrap  output  1  one-cycle pulse when the scan pointer wraps from N-1 to 0.

Behaviour:
- Reset: asserting rst immediately (asynchronously) forces out=0, out_valid=0, cur_sel=0, sel_err=0, wrap=0, dwell counter=0. Reset mid-scan discards the pointer; scan restarts at channel 0.
- Internal state: cur_sel register, dwell counter dcnt (holds 0..DWELL-1).
- en=0: out, cur_sel, sel_err and dcnt hold; out_valid<=0 and wrap<=0 on that edge.
- Manual mode (en=1, mode=0), latency 1 cycle:
  - cur_sel<=sel.
  - If sel<N: out<=din channel sel, sel_err<=0, out_valid<=1.
  - If sel>=N: out<=0, sel_err<=1, out_valid<=0.
  - dcnt<=0, wrap<=0.
- Scan mode (en=1, mode=1), each edge:
  - If cur_sel>=N (left illegal by manual mode): cur_sel<=0, dcnt<=0, out<=0, sel_err<=1, out_valid<=0, wrap<=0.
  - Otherwise: out<=din channel cur_sel, sel_err<=0, out_valid<=1.
    - If dcnt<DWELL-1: dcnt<=dcnt+1, wrap<=0.
    - If dcnt==DWELL-1: dcnt<=0, cur_sel<=(cur_sel==N-1) ? 0 : cur_sel+1, wrap<=(cur_sel==N-1).
- Note on cur_sel in scan mode: out is sampled from the pre-edge cur_sel. On the edge where the pointer advances, cur_sel already shows the next channel while out still shows the last sample of the previous channel.
- Mode changes take effect on the same edge; no extra cycle.
  - Manual->scan: scan starts from the current cur_sel with dcnt=0.
  - Scan->manual: dcnt is cleared.
- DWELL=1: pointer advances every enabled cycle; wrap pulses every N enabled cycles.
- din changes are visible at out only on an enabled edge. Output is fully registered; there is no combinational path from inputs to outputs.

Test Plan:
- Bench configuration: W=4, N=7, DWELL=4, din channel k = k+1 (4'h1..4'h7).
- Manual sweep: en=1, mode=0, sel=0..7 on consecutive cycles -> out 1,2,3,4,5,6,7 one cycle after each sel with out_valid=1, sel_err=0. sel=7 -> out=0, sel_err=1, out_valid=0, cur_sel=7.
- Scan from reset: release rst, en=1, mode=1 for 30 cycles -> out=1 for 4 cycles, then 2 for 4, ... 7 for 4. wrap=1 exactly on the edge where cur_sel returns to 0 (cycle 28). out=1 again from cycle 29.
- Illegal entry: manual sel=7, then mode=1 -> first scan edge gives cur_sel=0, out=0, sel_err=1, out_valid=0. The following 4 edges give out=1, out_valid=1.
- Enable gating mid-scan: on channel 3 with dcnt=2, drop en for 5 cycles -> out=4, cur_sel=3 held, out_valid=0, no wrap. On re-enable, 2 more cycles of out=4, then out=5.
- Async reset mid-operation: assert rst between clock edges while scanning channel 5 -> outputs zero immediately, without waiting for a clock edge. After release, scan resumes at channel 0 with the full 4-cycle dwell.
- DWELL=1 build: scan mode gives out 1,2,3,4,5,6,7,1,... on consecutive cycles. wrap pulses once every 7 enabled cycles.
